// File: rtl/i2c_calc_core.sv
// Byte-framed calculator behind an I2C slave: opcode/A/B write frame, 16-bit result
// and status readable through a cycling read pointer. Define CALC_MUL_EN to enable MUL (opcode 3).
module i2c_calc_core (
  input  logic       clk,
  input  logic       RST,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_start,
  input  logic       rx_stop,
  input  logic       tx_req,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GET_A = 2'd1;
  localparam logic [1:0] GET_B = 2'd2;
  localparam logic [1:0] EXEC  = 2'd3;

  localparam logic [1:0] PTR_STATUS = 2'd0;
  localparam logic [1:0] PTR_RES_HI = 2'd1;
  localparam logic [1:0] PTR_RES_LO = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic [1:0]  st;
  logic        invalid;
  logic        finish;
  logic [15:0] alu_res;

`ifdef CALC_MUL_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_sum;
`endif

  assign tx_data = tx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
`ifdef CALC_MUL_EN
    invalid = |opcode_q[7:2];
`else
    invalid = (|opcode_q[7:2]) || (opcode_q[1:0] == 2'd3);
`endif
    case (opcode_q[1:0])
      2'd0:    alu_res = {8'h00, a_q} + {8'h00, b_q};
      2'd1:    alu_res = {8'h00, a_q} - {8'h00, b_q};
      2'd2:    alu_res = {8'h00, a_q ^ b_q};
      default: alu_res = '1;
    endcase
  end

  always_comb begin
    st       = state_q;
    ptr_d    = ptr_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    finish   = 1'b0;
`ifdef CALC_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_sum  = '0;
`endif

    if (rx_start) begin
      ptr_d = PTR_STATUS;
    end else if (tx_req) begin
      ptr_d = (ptr_q == PTR_RES_LO) ? PTR_STATUS : ptr_q + 2'd1;
    end

    // Start, then stop, then the byte are applied in that order, each seeing the state left by the previous.
    if (rx_start && (st == GET_A || st == GET_B)) st = IDLE;
    if (rx_stop && (st == GET_A || st == GET_B)) begin
      ferr_d = 1'b1;
      st     = IDLE;
    end

    if (rx_valid) begin
      case (st)
        IDLE: begin
          opcode_d = rx_data;
          err_d    = 1'b0;
          ferr_d   = 1'b0;
          ovr_d    = 1'b0;
          st       = GET_A;
        end
        GET_A: begin
          a_d = rx_data;
          st  = GET_B;
        end
        GET_B: begin
          b_d    = rx_data;
          busy_d = 1'b1;
          st     = EXEC;
`ifdef CALC_MUL_EN
          acc_d    = '0;
          mcand_d  = {8'h00, a_q};
          mplier_d = rx_data;
          cnt_d    = '0;
`endif
        end
        default: ovr_d = 1'b1;
      endcase
    end

    if (state_q == EXEC) begin
`ifdef CALC_MUL_EN
      if (!invalid && opcode_q[1:0] == 2'd3) begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = acc_sum;
          finish   = 1'b1;
        end
      end else begin
        result_d = invalid ? 16'hFFFF : alu_res;
        if (invalid) err_d = 1'b1;
        finish = 1'b1;
      end
`else
      result_d = invalid ? 16'hFFFF : alu_res;
      if (invalid) err_d = 1'b1;
      finish = 1'b1;
`endif
      if (finish) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        st     = IDLE;
      end
    end

    state_d = st;

    // Read byte is built from next-state values so tx_data tracks the pointer without extra lag.
    case (ptr_d)
      PTR_RES_HI: tx_data_d = result_d[15:8];
      PTR_RES_LO: tx_data_d = result_d[7:0];
      default:    tx_data_d = {busy_d, 4'b0000, ovr_d, ferr_d, err_d};
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_STATUS;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef CALC_MUL_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_calc_core.sv
// Directed bench for i2c_calc_core: vector table of complete frames plus hand sequences
// for abort, stop, overrun, pointer wrap and reset-during-execution cases.
module tb_i2c_calc_core;

  logic       clk = 1'b0;
  logic       RST;
  logic       rx_valid, rx_start, rx_stop, tx_req;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  i2c_calc_core dut (
    .clk(clk), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_start(rx_start), .rx_stop(rx_stop), .tx_req(tx_req),
    .tx_data(tx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op, a, b;
    logic [15:0] res;
    logic [7:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send3(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = op;
    @(negedge clk); rx_data = a;
    @(negedge clk); rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 50);
  endtask

  task automatic read_all(input string name, input logic [7:0] st, input logic [15:0] res);
    @(negedge clk); rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0;
    check({name, " status"}, {8'h00, tx_data}, {8'h00, st});
    tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
    check({name, " res_hi"}, {8'h00, tx_data}, {8'h00, res[15:8]});
    tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
    check({name, " res_lo"}, {8'h00, tx_data}, {8'h00, res[7:0]});
  endtask

  initial begin
    int cyc;
    int pulses;
    vecs[0] = '{8'h00, 8'hC8, 8'h64, 16'h012C, 8'h00, 1};
    vecs[1] = '{8'h01, 8'h05, 8'h0A, 16'hFFFB, 8'h00, 1};
    vecs[2] = '{8'h02, 8'h0F, 8'hF0, 16'h00FF, 8'h00, 1};
`ifdef CALC_MUL_EN
    vecs[3] = '{8'h03, 8'hFF, 8'hFF, 16'hFE01, 8'h00, 8};
    vecs[6] = '{8'h03, 8'h0D, 8'h0B, 16'h008F, 8'h00, 8};
`else
    vecs[3] = '{8'h03, 8'hFF, 8'hFF, 16'hFFFF, 8'h01, 1};
    vecs[6] = '{8'h03, 8'h0D, 8'h0B, 16'hFFFF, 8'h01, 1};
`endif
    vecs[4] = '{8'h04, 8'h12, 8'h34, 16'hFFFF, 8'h01, 1};
    vecs[5] = '{8'h01, 8'h00, 8'h01, 16'hFFFF, 8'h00, 1};
    vecs[7] = '{8'h00, 8'hFF, 8'hFF, 16'h01FE, 8'h00, 1};

    RST = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_start = 1'b0; rx_stop = 1'b0; tx_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx_data", {8'h00, tx_data}, 16'h0000);
    check("reset busy", {15'd0, busy}, 16'h0000);
    check("reset done", {15'd0, done}, 16'h0000);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send3(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d busy", i), {15'd0, busy}, 16'h0001);
      wait_done(cyc);
      check($sformatf("vec%0d latency", i), cyc[15:0], vecs[i].lat[15:0]);
      check($sformatf("vec%0d busy_at_done", i), {15'd0, busy}, 16'h0000);
      read_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].res);
    end

    // Pointer wrap after a completed ADD
    send3(8'h00, 8'hC8, 8'h64);
    wait_done(cyc);
    @(negedge clk); rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0;
    check("wrap status0", {8'h00, tx_data}, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] wexp [4];
      wexp = '{8'h01, 8'h2C, 8'h00, 8'h01};
      tx_req = 1'b1;
      @(negedge clk); tx_req = 1'b0;
      check($sformatf("wrap step%0d", k), {8'h00, tx_data}, {8'h00, wexp[k]});
    end

    // rx_start in GET_B aborts; result stays 012C
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h01;
    @(negedge clk); rx_data = 8'h11;
    @(negedge clk); rx_valid = 1'b0; rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (done) pulses++; end
    check("abort no done", pulses[15:0], 16'h0000);
    read_all("abort", 8'h00, 16'h012C);

    // Overrun: fourth back-to-back byte lands in the single EXEC cycle
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h00;
    @(negedge clk); rx_data = 8'h01;
    @(negedge clk); rx_data = 8'h02;
    @(negedge clk); rx_data = 8'hAA;
    @(negedge clk); rx_valid = 1'b0;
    check("ovr done", {15'd0, done}, 16'h0001);
    read_all("ovr", 8'h04, 16'h0003);

    // rx_stop mid-frame sets ferr; then start with same-cycle opcode byte
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h00;
    @(negedge clk); rx_data = 8'h11;
    @(negedge clk); rx_valid = 1'b0; rx_stop = 1'b1;
    @(negedge clk); rx_stop = 1'b0;
    read_all("stop", 8'h02, 16'h0003);
    @(negedge clk); rx_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
    @(negedge clk); rx_start = 1'b0; rx_data = 8'h0F;
    @(negedge clk); rx_data = 8'hF0;
    @(negedge clk); rx_valid = 1'b0;
    wait_done(cyc);
    check("start+valid latency", cyc[15:0], 16'h0001);
    read_all("start+valid", 8'h00, 16'h00FF);

`ifdef CALC_MUL_EN
    // Overrun during MUL, status and previous result readable while busy
    send3(8'h03, 8'h02, 8'h03);
    rx_valid = 1'b1; rx_data = 8'h55; rx_start = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rx_start = 1'b0;
    check("mul busy status", {8'h00, tx_data}, 16'h0084);
    tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
    check("mul busy res_hi", {8'h00, tx_data}, 16'h0000);
    tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
    check("mul busy res_lo", {8'h00, tx_data}, 16'h00FF);
    wait_done(cyc);
    check("mul ovr done seen", {15'd0, done}, 16'h0001);
    read_all("mul ovr", 8'h04, 16'h0006);
`endif

    // Reset while executing discards the computation
    send3(8'h03, 8'hFF, 8'hFF);
    RST = 1'b1;
    #1;
    check("rst tx_data", {8'h00, tx_data}, 16'h0000);
    check("rst busy", {15'd0, busy}, 16'h0000);
    @(negedge clk); RST = 1'b0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (done) pulses++; end
    check("rst no done", pulses[15:0], 16'h0000);
    read_all("rst", 8'h00, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
